// File: rtl/mc_main_ctrl.sv
// Multi-cycle MIPS main control unit: Moore FSM sequencing fetch, decode and
// per-class execution, with a latched opcode and a one-cycle illegal-opcode flag.
module mc_main_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    output logic       pcWrite,
    output logic       pcWriteCond,
    output logic       iorD,
    output logic       memRead,
    output logic       memWrite,
    output logic       irWrite,
    output logic       memToReg,
    output logic       regDst,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] aluOp,
    output logic [1:0] pcSource,
    output logic       instrDone,
    output logic       illegalOp,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_IEXEC  = 4'd10,
        S_IWB    = 4'd11,
        S_RST    = 4'd15
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;

    state_t     cur;
    state_t     nxt;
    logic [5:0] opReg;

    function automatic logic is_legal(input logic [5:0] op);
        return (op == OP_R) || (op == OP_LW) || (op == OP_SW) || (op == OP_BEQ) ||
               (op == OP_J) || (op == OP_ADDI) || (op == OP_ANDI);
    endfunction

    // opReg and illegalOp are both captured only on the edge that leaves DECODE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur       <= S_RST;
            opReg     <= 6'd0;
            illegalOp <= 1'b0;
        end else begin
            cur       <= nxt;
            illegalOp <= (cur == S_DECODE) && !is_legal(opcode);
            if (cur == S_DECODE)
                opReg <= opcode;
        end
    end

    always_comb begin
        nxt         = S_FETCH;
        pcWrite     = 1'b0;
        pcWriteCond = 1'b0;
        iorD        = 1'b0;
        memRead     = 1'b0;
        memWrite    = 1'b0;
        irWrite     = 1'b0;
        memToReg    = 1'b0;
        regDst      = 1'b0;
        regWrite    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        aluOp       = 2'b00;
        pcSource    = 2'b00;
        instrDone   = 1'b0;
        case (cur)
            S_RST: nxt = S_FETCH;
            S_FETCH: begin
                nxt     = S_DECODE;
                memRead = 1'b1;
                irWrite = 1'b1;
                aluSrcB = 2'b01;
                pcWrite = 1'b1;
            end
            // The live opcode is only trusted here; later states use opReg
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:     nxt = S_MEMADR;
                    OP_R:             nxt = S_EXEC;
                    OP_BEQ:           nxt = S_BRANCH;
                    OP_J:             nxt = S_JUMP;
                    OP_ADDI, OP_ANDI: nxt = S_IEXEC;
                    default:          nxt = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                nxt     = (opReg == OP_LW) ? S_MEMRD : S_MEMWR;
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
            end
            S_MEMRD: begin
                nxt     = S_MEMWB;
                memRead = 1'b1;
                iorD    = 1'b1;
            end
            S_MEMWB: begin
                regWrite  = 1'b1;
                memToReg  = 1'b1;
                instrDone = 1'b1;
            end
            S_MEMWR: begin
                memWrite  = 1'b1;
                iorD      = 1'b1;
                instrDone = 1'b1;
            end
            S_EXEC: begin
                nxt     = S_ALUWB;
                aluSrcA = 1'b1;
                aluOp   = 2'b10;
            end
            S_ALUWB: begin
                regWrite  = 1'b1;
                regDst    = 1'b1;
                instrDone = 1'b1;
            end
            S_BRANCH: begin
                aluSrcA     = 1'b1;
                aluOp       = 2'b01;
                pcWriteCond = 1'b1;
                pcSource    = 2'b01;
                instrDone   = 1'b1;
            end
            S_JUMP: begin
                pcWrite   = 1'b1;
                pcSource  = 2'b10;
                instrDone = 1'b1;
            end
            S_IEXEC: begin
                nxt     = S_IWB;
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                aluOp   = (opReg == OP_ANDI) ? 2'b11 : 2'b00;
            end
            S_IWB: begin
                regWrite  = 1'b1;
                instrDone = 1'b1;
            end
            default: nxt = S_FETCH;
        endcase
    end

    assign state = cur;

endmodule

// File: tb/tb_mc_main_ctrl.sv
// Self-checking bench for mc_main_ctrl: directed scenarios plus randomized
// instruction streams and resets, checked against an instruction-level model.
module tb_mc_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode;
    logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
    logic       memToReg, regDst, regWrite, aluSrcA, instrDone, illegalOp;
    logic [1:0] aluSrcB, aluOp, pcSource;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;
    logic prev_ill = 1'b0;
    int exp_q[$];

    mc_main_ctrl dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode),
        .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
        .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
        .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
        .pcSource(pcSource), .instrDone(instrDone), .illegalOp(illegalOp),
        .state(state)
    );

    always #5 clk = ~clk;

    // Field order: pw pwc iord mr mw irw m2r rdst rw asa asb[2] aop[2] psrc[2] done
    wire [16:0] ctrl = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                        memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                        pcSource, instrDone};

    function automatic logic legal(input logic [5:0] op);
        return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                          6'b000010, 6'b001000, 6'b001100};
    endfunction

    // Instruction-level state walk, straight from the instruction class
    task automatic build_seq(input logic [5:0] op);
        exp_q = '{0, 1};
        case (op)
            6'b100011: exp_q = {exp_q, 2, 3, 4};
            6'b101011: exp_q = {exp_q, 2, 5};
            6'b000000: exp_q = {exp_q, 6, 7};
            6'b000100: exp_q = {exp_q, 8};
            6'b000010: exp_q = {exp_q, 9};
            6'b001000, 6'b001100: exp_q = {exp_q, 10, 11};
            default: ;
        endcase
    endtask

    function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] op);
        logic pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done;
        logic [1:0] asb, aop, psrc;
        {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, done} = '0;
        asb = 2'b00; aop = 2'b00; psrc = 2'b00;
        case (st)
            0:  begin mr = 1; irw = 1; asb = 2'b01; pw = 1; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mr = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; done = 1; end
            5:  begin mw = 1; iord = 1; done = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rdst = 1; done = 1; end
            8:  begin asa = 1; aop = 2'b01; pwc = 1; psrc = 2'b01; done = 1; end
            9:  begin pw = 1; psrc = 2'b10; done = 1; end
            10: begin asa = 1; asb = 2'b10; aop = (op == 6'b001100) ? 2'b11 : 2'b00; end
            11: begin rw = 1; done = 1; end
            default: ;
        endcase
        return {pw, pwc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, done};
    endfunction

    // Runs one instruction from its FETCH negedge; alt replaces opcode after DECODE.
    // abort_at >= 0 asserts reset during that step and checks the async response.
    task automatic run_instr(input logic [5:0] op, input logic [5:0] alt, input int abort_at);
        build_seq(op);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == 0) opcode = op;
            if (i >= 2) opcode = alt;
            #1;
            checks++;
            if (state !== 4'(exp_q[i])) begin
                errors++;
                $display("FAIL state op=%b step=%0d actual=%0d required=%0d", op, i, state, exp_q[i]);
            end
            checks++;
            if (ctrl !== exp_ctrl(exp_q[i], op)) begin
                errors++;
                $display("FAIL ctrl op=%b step=%0d actual=%b required=%b", op, i, ctrl, exp_ctrl(exp_q[i], op));
            end
            checks++;
            if (illegalOp !== ((i == 0) ? prev_ill : 1'b0)) begin
                errors++;
                $display("FAIL illegalOp op=%b step=%0d actual=%b required=%b", op, i, illegalOp, (i == 0) ? prev_ill : 1'b0);
            end
            if (i == abort_at) begin
                #1 rst_n = 1'b0;
                #1;
                checks++;
                if (state !== 4'hF || ctrl !== 17'd0 || illegalOp !== 1'b0) begin
                    errors++;
                    $display("FAIL async_reset step=%0d actual state=%0d ctrl=%b ill=%b required state=15 ctrl=0 ill=0", i, state, ctrl, illegalOp);
                end
                @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                checks++;
                if (state !== 4'd0) begin
                    errors++;
                    $display("FAIL reset_release actual=%0d required=0", state);
                end
                prev_ill = 1'b0;
                return;
            end
            @(negedge clk);
        end
        prev_ill = !legal(op);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        opcode = 6'd0;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (state !== 4'hF || ctrl !== 17'd0 || illegalOp !== 1'b0) begin
            errors++;
            $display("FAIL reset_state actual state=%0d ctrl=%b required state=15 ctrl=0", state, ctrl);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (state !== 4'hF) begin
            errors++;
            $display("FAIL reset_hold actual=%0d required=15", state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL reset_to_fetch actual=%0d required=0", state);
        end
        prev_ill = 1'b0;
    endtask

    task automatic test_lw();
        run_instr(6'b100011, 6'b000000, -1);
    endtask

    task automatic test_r_beq();
        int n, done_cnt;
        run_instr(6'b000000, 6'b111111, -1);
        run_instr(6'b000100, 6'b000000, -1);
        // DUT-observed length of R followed by beq
        opcode = 6'b000000;
        n = 0;
        done_cnt = 0;
        while (done_cnt < 2 && n < 20) begin
            #1;
            n++;
            if (instrDone === 1'b1) begin
                done_cnt++;
                opcode = 6'b000100;
            end
            @(negedge clk);
        end
        checks++;
        if (n !== 7 || done_cnt !== 2) begin
            errors++;
            $display("FAIL r_beq_cycles actual=%0d dones=%0d required=7 dones=2", n, done_cnt);
        end
    endtask

    task automatic test_opreg_hold();
        run_instr(6'b001100, 6'b001000, -1);
        run_instr(6'b101011, 6'b100011, -1);
        run_instr(6'b001000, 6'b001100, -1);
    endtask

    task automatic test_illegal();
        run_instr(6'b111111, 6'b000000, -1);
        run_instr(6'b000010, 6'b111111, -1);
    endtask

    task automatic test_reset_in_memwr();
        run_instr(6'b101011, 6'b000000, 3);
    endtask

    task automatic test_random();
        logic [5:0] ops [7] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
                                6'b000010, 6'b001000, 6'b001100};
        logic [5:0] op, alt;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(9) < 7) op = ops[$urandom_range(6)];
            else op = 6'($urandom);
            alt = 6'($urandom);
            build_seq(op);
            if (k % 10 == 9) run_instr(op, alt, int'($urandom_range(exp_q.size() - 1)));
            else run_instr(op, alt, -1);
        end
    endtask

    task automatic test_back_to_back();
        for (int k = 0; k < 4; k++)
            run_instr(6'b111111 - 6'(k), 6'($urandom), -1);
        run_instr(6'b100011, 6'($urandom), -1);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_beq();
        test_opreg_hold();
        test_illegal();
        test_reset_in_memwr();
        test_back_to_back();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/mc_main_ctrl.md
MC_MAIN_CTRL -- requirements
Module: mc_main_ctrl

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk and rst_n, with no other clock or reset.
REQ-002 The ports SHALL be as follows:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- opcode  in  6  instruction[31:26], valid from DECODE onward.
- pcWrite  out  1  unconditional PC load.
- pcWriteCond  out  1  PC load qualified by ALU zero.
- iorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- memRead  out  1  memory read.
- memWrite  out  1  memory write.
- irWrite  out  1  IR load.
- memToReg  out  1  write-back select: 1 = MDR, 0 = ALUOut.
- regDst  out  1  destination select: 1 = rd, 0 = rt.
- regWrite  out  1  register-file write.
- aluSrcA  out  1  ALU A select: 0 = PC, 1 = A.
- aluSrcB  out  2  ALU B select: 00 = B, 01 = 4, 10 = signext, 11 = signext<<2.
- aluOp  out  2  to ALU control: 00 = add, 01 = sub, 10 = funct, 11 = and.
- pcSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target.
- instrDone  out  1  last cycle of an instruction.
- illegalOp  out  1  one-cycle unsupported-opcode flag.
- state  out  4  current state, for debug.

Function
REQ-003 The state encoding SHALL be: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, RST=15.
REQ-004 The supported opcodes SHALL be: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100.
REQ-005 Transitions SHALL be: RST->FETCH; FETCH->DECODE; DECODE->MEMADR (lw/sw), EXEC (R), BRANCH (beq), JUMP (j), IEXEC (addi/andi), FETCH (any other opcode).
REQ-006 Further transitions SHALL be: MEMADR->MEMRD (lw) or MEMWR (sw); MEMRD->MEMWB; EXEC->ALUWB; IEXEC->IWB; MEMWB, MEMWR, ALUWB, IWB, BRANCH and JUMP each go to FETCH.
REQ-007 The opcode SHALL be registered into opReg on the DECODE cycle; all decisions after DECODE SHALL use opReg only, so input changes after DECODE have no effect.
REQ-008 All control outputs SHALL be Moore outputs decoded from state (plus opReg where stated); any output not listed for a state SHALL be 0.
REQ-009 FETCH outputs SHALL be: memRead=1, irWrite=1, aluSrcB=01, pcWrite=1; iorD, aluSrcA, aluOp and pcSource are 0.
REQ-010 DECODE outputs SHALL be: aluSrcB=11, aluOp=00. MEMADR outputs SHALL be: aluSrcA=1, aluSrcB=10, aluOp=00.
REQ-011 MEMRD outputs SHALL be: memRead=1, iorD=1. MEMWR outputs SHALL be: memWrite=1, iorD=1. MEMWB outputs SHALL be: regWrite=1, memToReg=1, regDst=0.
REQ-012 EXEC outputs SHALL be: aluSrcA=1, aluSrcB=00, aluOp=10. ALUWB outputs SHALL be: regWrite=1, regDst=1.
REQ-013 BRANCH outputs SHALL be: aluSrcA=1, aluSrcB=00, aluOp=01, pcWriteCond=1, pcSource=01. JUMP outputs SHALL be: pcWrite=1, pcSource=10.
REQ-014 IEXEC outputs SHALL be: aluSrcA=1, aluSrcB=10, with aluOp=00 if opReg is addi and 11 if opReg is andi. IWB outputs SHALL be: regWrite=1, regDst=0, memToReg=0.
REQ-015 instrDone SHALL be 1 exactly in MEMWB, MEMWR, ALUWB, IWB, BRANCH and JUMP.
REQ-016 Cycles per instruction, counted from FETCH, SHALL be: lw 5; sw, R-type, addi and andi 4; beq and j 3; unsupported 2.
REQ-017 illegalOp SHALL be a register set on the clock edge that leaves DECODE on an unsupported opcode, and SHALL be high for exactly the following FETCH cycle only; no other output changes for an illegal opcode.
REQ-018 memRead and memWrite SHALL never both be 1 in the same cycle, and regWrite SHALL never be 1 in FETCH or DECODE.

Reset
REQ-019 Asserting rst_n low SHALL, without waiting for a clock edge, force state=RST (4'hF), opReg=0 and illegalOp=0, so every control output and instrDone read 0.
REQ-020 The first rising clk after rst_n deasserts SHALL move the block from RST to FETCH.
REQ-021 Reset asserted in any state, mid-instruction included, SHALL abandon that instruction with no further register-file or memory write.

Verification
REQ-022 Reset then release, opcode=100011 (lw): states SHALL be 15,0,1,2,3,4,0; memRead=1 in states 0 and 3; regWrite=1 and memToReg=1 in state 4 only; instrDone pulses once.
REQ-023 opcode=000000 (R-type) then 000100 (beq): aluOp=10 in EXEC, then aluOp=01 with pcWriteCond=1 and pcSource=01 in BRANCH; the whole sequence takes 7 cycles.
REQ-024 opcode=001100 (andi) with opcode changed to 001000 after DECODE: aluOp SHALL be 11 in IEXEC because opReg holds andi.
REQ-025 opcode=111111: states SHALL be 0,1,0; illegalOp=1 in the second FETCH only; memWrite and regWrite stay 0 throughout.
REQ-026 rst_n driven low during MEMWR of sw: memWrite SHALL drop to 0 immediately and state SHALL read 15 before the next clock edge.
